ps2_kbd_ctrl: RTL and testbench

//   Sequencer/decoder behind the PS2 byte receiver. Gates the receiver via rx_en,

---
 rtl/ps2_kbd_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_ps2_kbd_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_kbd_ctrl.sv
// ---------------------------------------------------------------------------
// ps2_kbd_ctrl
//   Sequencer/decoder that sits behind a PS2 byte receiver. It gates the
//   receiver, folds scan-code set 2 prefixes (E0 extended, F0 break) into
//   single key events, buffers the events in a small FIFO and hands them to
//   the consumer through a valid/pop handshake. Dropped events (FIFO full)
//   and abandoned prefixes (timeout) are reported by sticky flags.
//
// Ports
//   clk          system clock, shared with the PS2 receiver
//   reset        asynchronous reset, active low
//   enable       1 = accept keyboard traffic
//   rx_done_tick one-cycle strobe, rx_data valid
//   rx_data      received byte
//   rx_en        receiver enable = enable & ~fifo_full
//   ev_valid     FIFO non-empty
//   ev_data      head event {ext, brk, code[7:0]}
//   ev_pop       consume head event (ignored when empty)
//   ovf          sticky: event dropped because FIFO full
//   tmo          sticky: prefix timed out and was discarded
//   clr_flags    synchronous clear of ovf/tmo (a same-cycle set wins)
//   fifo_count   number of stored events, 0..DEPTH
// ---------------------------------------------------------------------------
module ps2_kbd_ctrl #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 20000,
  parameter int TW      = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     rx_done_tick,
  input  logic [7:0]               rx_data,
  output logic                     rx_en,
  output logic                     ev_valid,
  output logic [9:0]               ev_data,
  input  logic                     ev_pop,
  output logic                     ovf,
  output logic                     tmo,
  input  logic                     clr_flags,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXT,
    S_BRK,
    S_EXTBRK
  } state_t;

  state_t          r_state, w_next;
  logic [TW-1:0]   r_cnt;
  logic [9:0]      r_mem [DEPTH];
  logic [AW-1:0]   r_wr, r_rd;
  logic [AW:0]     r_count;
  logic            r_ovf, r_tmo;

  logic            w_tick;
  logic            w_push;
  logic [9:0]      w_ev;
  logic            w_tmo_hit;
  logic            w_full, w_empty;
  logic            w_do_pop, w_do_push, w_drop;

  // Acknowledge / BAT / echo / resend / error codes never form key events.
  function automatic logic is_filtered(input logic [7:0] b);
    return (b == 8'hAA) || (b == 8'hFA) || (b == 8'hEE) ||
           (b == 8'hFE) || (b == 8'h00) || (b == 8'hFF);
  endfunction

  assign w_tick  = rx_done_tick & enable;
  assign w_full  = (r_count == (AW+1)'(DEPTH));
  assign w_empty = (r_count == '0);

  // ---------------- decoder FSM: next state / push ----------------
  always_comb begin
    w_next    = r_state;
    w_push    = 1'b0;
    w_ev      = '0;
    w_tmo_hit = 1'b0;
    if (!enable) begin
      w_next = S_IDLE;
    end else if (w_tick) begin
      unique case (r_state)
        S_IDLE: begin
          if (rx_data == 8'hE0)       w_next = S_EXT;
          else if (rx_data == 8'hF0)  w_next = S_BRK;
          else if (!is_filtered(rx_data)) begin
            w_push = 1'b1;
            w_ev   = {2'b00, rx_data};
          end
        end
        S_EXT: begin
          if (rx_data == 8'hF0)       w_next = S_EXTBRK;
          else if (rx_data == 8'hE0)  w_next = S_EXT;
          else begin
            w_next = S_IDLE;
            if (!is_filtered(rx_data)) begin
              w_push = 1'b1;
              w_ev   = {2'b10, rx_data};
            end
          end
        end
        S_BRK: begin
          if (rx_data == 8'hE0 || rx_data == 8'hF0) w_next = S_BRK;
          else begin
            w_next = S_IDLE;
            if (!is_filtered(rx_data)) begin
              w_push = 1'b1;
              w_ev   = {2'b01, rx_data};
            end
          end
        end
        S_EXTBRK: begin
          if (rx_data == 8'hE0 || rx_data == 8'hF0) w_next = S_EXTBRK;
          else begin
            w_next = S_IDLE;
            if (!is_filtered(rx_data)) begin
              w_push = 1'b1;
              w_ev   = {2'b11, rx_data};
            end
          end
        end
        default: w_next = S_IDLE;
      endcase
    end else if (r_state != S_IDLE && r_cnt == TW'(TIMEOUT - 1)) begin
      // A byte in the same cycle takes priority, hence the else-chain.
      w_next    = S_IDLE;
      w_tmo_hit = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // ---------------- prefix timeout counter ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (!enable || w_tick || r_state == S_IDLE || w_tmo_hit) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // ---------------- event FIFO ----------------
  assign w_do_pop  = ev_pop & ~w_empty;
  // When full, a push only fits if the head leaves in the same cycle.
  assign w_do_push = w_push & (~w_full | w_do_pop);
  assign w_drop    = w_push & w_full & ~w_do_pop;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr] <= w_ev;
        r_wr        <= r_wr + 1'b1;
      end
      if (w_do_pop) r_rd <= r_rd + 1'b1;
      if (w_do_push && !w_do_pop)      r_count <= r_count + 1'b1;
      else if (w_do_pop && !w_do_push) r_count <= r_count - 1'b1;
    end
  end

  // ---------------- sticky flags ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ovf <= 1'b0;
      r_tmo <= 1'b0;
    end else begin
      if (w_drop)         r_ovf <= 1'b1;
      else if (clr_flags) r_ovf <= 1'b0;
      if (w_tmo_hit)      r_tmo <= 1'b1;
      else if (clr_flags) r_tmo <= 1'b0;
    end
  end

  assign rx_en      = enable & ~w_full;
  assign ev_valid   = ~w_empty;
  assign ev_data    = r_mem[r_rd];
  assign ovf        = r_ovf;
  assign tmo        = r_tmo;
  assign fifo_count = r_count;

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ps2_kbd_ctrl
//   Directed bench for ps2_kbd_ctrl with hand-computed expected events.
//   Inputs change on the falling edge; outputs are sampled on the falling
//   edge, half a period away from the active rising edge.
// ---------------------------------------------------------------------------
module tb_ps2_kbd_ctrl;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 50;
  localparam int TW      = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       rx_done_tick;
  logic [7:0] rx_data;
  logic       rx_en;
  logic       ev_valid;
  logic [9:0] ev_data;
  logic       ev_pop;
  logic       ovf;
  logic       tmo;
  logic       clr_flags;
  logic [2:0] fifo_count;

  int n_tests = 0;
  int n_fail  = 0;

  ps2_kbd_ctrl #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .TW(TW)) u_dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .rx_done_tick (rx_done_tick),
    .rx_data      (rx_data),
    .rx_en        (rx_en),
    .ev_valid     (ev_valid),
    .ev_data      (ev_data),
    .ev_pop       (ev_pop),
    .ovf          (ovf),
    .tmo          (tmo),
    .clr_flags    (clr_flags),
    .fifo_count   (fifo_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One received byte; returns on the falling edge after the capture edge.
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data      = b;
    rx_done_tick = 1'b1;
    @(negedge clk);
    rx_done_tick = 1'b0;
  endtask

  task automatic pop_one();
    @(negedge clk);
    ev_pop = 1'b1;
    @(negedge clk);
    ev_pop = 1'b0;
  endtask

  task automatic clear_flags();
    @(negedge clk);
    clr_flags = 1'b1;
    @(negedge clk);
    clr_flags = 1'b0;
  endtask

  logic [7:0] fill_codes [4];
  logic [9:0] fill_exp   [4];

  initial begin
    fill_codes[0] = 8'h15; fill_codes[1] = 8'h1D;
    fill_codes[2] = 8'h24; fill_codes[3] = 8'h2D;
    fill_exp[0] = 10'h015; fill_exp[1] = 10'h01D;
    fill_exp[2] = 10'h024; fill_exp[3] = 10'h02D;

    reset = 1'b0; enable = 1'b1; rx_done_tick = 1'b0; rx_data = 8'h00;
    ev_pop = 1'b0; clr_flags = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid", 32'(ev_valid), 32'd0);
    check("rst_count", 32'(fifo_count), 32'd0);
    check("rst_data",  32'(ev_data), 32'd0);
    check("rst_ovf",   32'(ovf), 32'd0);
    check("rst_tmo",   32'(tmo), 32'd0);
    check("rst_rx_en", 32'(rx_en), 32'd1);
    reset = 1'b1;

    // 1: plain make code
    send_byte(8'h1C);
    check("t1_valid", 32'(ev_valid), 32'd1);
    check("t1_data",  32'(ev_data), 32'h01C);
    pop_one();
    check("t1_popped", 32'(ev_valid), 32'd0);

    // 2: break and extended break fold into one event each
    send_byte(8'hF0); send_byte(8'h1C);
    check("t2_brk_count", 32'(fifo_count), 32'd1);
    check("t2_brk_data",  32'(ev_data), 32'h11C);
    pop_one();
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
    check("t2_eb_count", 32'(fifo_count), 32'd1);
    check("t2_eb_data",  32'(ev_data), 32'h375);
    pop_one();
    send_byte(8'hE0); send_byte(8'h6B);
    check("t2_ext_data", 32'(ev_data), 32'h26B);
    pop_one();

    // 3: fill, overflow, drain in order
    for (int i = 0; i < 4; i++) send_byte(fill_codes[i]);
    check("t3_count_full", 32'(fifo_count), 32'd4);
    check("t3_rx_en_full", 32'(rx_en), 32'd0);
    send_byte(8'h35);
    check("t3_ovf",        32'(ovf), 32'd1);
    check("t3_head",       32'(ev_data), 32'h015);
    check("t3_count_ovf",  32'(fifo_count), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t3_order%0d", i), 32'(ev_data), 32'(fill_exp[i]));
      pop_one();
    end
    check("t3_rx_en_empty", 32'(rx_en), 32'd1);
    check("t3_empty",       32'(ev_valid), 32'd0);
    pop_one();  // pop while empty must not move pointers
    check("t3_pop_empty", 32'(fifo_count), 32'd0);
    clear_flags();
    check("t3_ovf_clr", 32'(ovf), 32'd0);

    // 4: prefix timeout, exact boundary
    send_byte(8'hE0);
    repeat (TIMEOUT - 1) @(negedge clk);
    check("t4_tmo_before", 32'(tmo), 32'd0);
    @(negedge clk);
    check("t4_tmo_at", 32'(tmo), 32'd1);
    send_byte(8'h1C);
    check("t4_after_data", 32'(ev_data), 32'h01C);
    pop_one();
    clear_flags();
    check("t4_tmo_clr", 32'(tmo), 32'd0);
    // a byte arriving mid-prefix keeps the prefix alive
    send_byte(8'hF0);
    repeat (TIMEOUT - 5) @(negedge clk);
    send_byte(8'h1C);
    check("t4_late_tmo",  32'(tmo), 32'd0);
    check("t4_late_data", 32'(ev_data), 32'h11C);
    pop_one();

    // 5: filtered codes
    send_byte(8'hAA); send_byte(8'hFA); send_byte(8'h00);
    check("t5_filt_count", 32'(fifo_count), 32'd0);
    send_byte(8'hE0); send_byte(8'hFF);
    check("t5_ext_ff_count", 32'(fifo_count), 32'd0);
    send_byte(8'h1C);
    check("t5_idle_data", 32'(ev_data), 32'h01C);
    pop_one();

    // enable=0: ticks ignored, contents retained, prefix lost
    send_byte(8'h1C);
    enable = 1'b0;
    send_byte(8'h2D);
    check("en0_count", 32'(fifo_count), 32'd1);
    check("en0_head",  32'(ev_data), 32'h01C);
    check("en0_rx_en", 32'(rx_en), 32'd0);
    pop_one();
    check("en0_pop", 32'(ev_valid), 32'd0);
    enable = 1'b1;
    send_byte(8'hE0);
    enable = 1'b0;
    @(negedge clk);
    enable = 1'b1;
    send_byte(8'h1C);
    check("en0_prefix_lost", 32'(ev_data), 32'h01C);
    pop_one();

    // 6: push and pop together while full
    for (int i = 0; i < 4; i++) send_byte(fill_codes[i]);
    @(negedge clk);
    rx_data = 8'h35; rx_done_tick = 1'b1; ev_pop = 1'b1;
    @(negedge clk);
    rx_done_tick = 1'b0; ev_pop = 1'b0;
    check("t6_count", 32'(fifo_count), 32'd4);
    check("t6_ovf",   32'(ovf), 32'd0);
    check("t6_head",  32'(ev_data), 32'h01D);
    pop_one(); pop_one(); pop_one();
    check("t6_tail", 32'(ev_data), 32'h035);
    pop_one();

    // set beats clear in the same cycle
    for (int i = 0; i < 4; i++) send_byte(fill_codes[i]);
    @(negedge clk);
    rx_data = 8'h44; rx_done_tick = 1'b1; clr_flags = 1'b1;
    @(negedge clk);
    rx_done_tick = 1'b0; clr_flags = 1'b0;
    check("t6_set_wins", 32'(ovf), 32'd1);

    // async reset after a prefix
    send_byte(8'hE0);
    #2 reset = 1'b0;
    #1;
    check("t6_rst_count", 32'(fifo_count), 32'd0);
    check("t6_rst_ovf",   32'(ovf), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    send_byte(8'h1C);
    check("t6_rst_data", 32'(ev_data), 32'h01C);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Guard against a hung run.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
